// File: rtl/seg_char_pkg.sv
// rtl/seg_char_pkg.sv - character codes shared by the display decoder and keypad decoder
package seg_char_pkg;

  typedef logic [5:0] char_code_t;

  localparam char_code_t CH_0     = 6'd0;
  localparam char_code_t CH_1     = 6'd1;
  localparam char_code_t CH_2     = 6'd2;
  localparam char_code_t CH_3     = 6'd3;
  localparam char_code_t CH_4     = 6'd4;
  localparam char_code_t CH_5     = 6'd5;
  localparam char_code_t CH_6     = 6'd6;
  localparam char_code_t CH_7     = 6'd7;
  localparam char_code_t CH_8     = 6'd8;
  localparam char_code_t CH_9     = 6'd9;
  localparam char_code_t CH_A     = 6'd10;
  localparam char_code_t CH_B     = 6'd11;
  localparam char_code_t CH_C     = 6'd12;
  localparam char_code_t CH_D     = 6'd13;
  localparam char_code_t CH_E     = 6'd14;
  localparam char_code_t CH_F     = 6'd15;
  localparam char_code_t CH_BLANK = 6'd16;

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - row dwell divider producing the column sample tick and row index
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       sample_tick,
  output logic [1:0] row
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div;

  // Columns are sampled at the very end of the dwell so they get the full dwell to settle
  assign sample_tick = (div == DW'(SCAN_DIV - 1));

  // Divider counts 0..SCAN_DIV-1, then the row index advances mod 4
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      row <= 2'd0;
    end else if (sample_tick) begin
      div <= '0;
      row <= row + 2'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_decoder.sv
// rtl/keypad_scan_decoder.sv - 4x4 keypad scanner with frame-level debounce and key code output
import seg_char_pkg::*;

module keypad_scan_decoder #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [5:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {FR_NONE, FR_ONE, FR_MULTI} frame_kind_t;
  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  logic [3:0]  col_meta, col_sync;
  logic        sample_tick;
  logic [1:0]  row;
  logic [3:0]  active;
  logic [2:0]  row_hits;
  logic [1:0]  hit_col;
  logic [2:0]  total_hits;
  logic [1:0]  sat_hits;
  logic [3:0]  new_pos;
  logic [1:0]  acc_hits;
  logic [3:0]  acc_pos;
  logic        frame_done;
  frame_kind_t frame_kind;
  logic [3:0]  frame_pos;
  state_t      state;
  logic [3:0]  cand;
  logic [CW-1:0] cnt;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .sample_tick (sample_tick),
    .row         (row)
  );

  // Key position {row, col} to character code; '*' and '#' show as E and F
  function automatic char_code_t key_map(input logic [3:0] pos);
    case (pos)
      4'd0:    return CH_1;
      4'd1:    return CH_2;
      4'd2:    return CH_3;
      4'd3:    return CH_A;
      4'd4:    return CH_4;
      4'd5:    return CH_5;
      4'd6:    return CH_6;
      4'd7:    return CH_B;
      4'd8:    return CH_7;
      4'd9:    return CH_8;
      4'd10:   return CH_9;
      4'd11:   return CH_C;
      4'd12:   return CH_E;
      4'd13:   return CH_0;
      4'd14:   return CH_F;
      default: return CH_D;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous, active-low column pins
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // Drive the next row low as soon as the current row has been sampled
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      row_out <= 4'b1110;
    end else if (sample_tick) begin
      row_out <= ~(4'b0001 << (row + 2'd1));
    end
  end

  // Count pressed columns in the current row; lowest column wins when only one is pressed
  always_comb begin
    active   = ~col_sync;
    row_hits = 3'd0;
    hit_col  = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (active[c]) begin
        row_hits = row_hits + 3'd1;
        hit_col  = 2'(c);
      end
    end
    total_hits = {1'b0, acc_hits} + row_hits;
    sat_hits   = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
    new_pos    = (row_hits == 3'd1) ? {row, hit_col} : acc_pos;
  end

  // Accumulate a whole frame; the result is published one cycle after row 3 is sampled
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc_hits   <= 2'd0;
      acc_pos    <= 4'd0;
      frame_done <= 1'b0;
      frame_kind <= FR_NONE;
      frame_pos  <= 4'd0;
    end else begin
      frame_done <= 1'b0;
      if (sample_tick) begin
        if (row == 2'd3) begin
          frame_done <= 1'b1;
          frame_kind <= (sat_hits == 2'd0) ? FR_NONE :
                        (sat_hits == 2'd1) ? FR_ONE : FR_MULTI;
          frame_pos  <= new_pos;
          acc_hits   <= 2'd0;
          acc_pos    <= 4'd0;
        end else begin
          acc_hits <= sat_hits;
          acc_pos  <= new_pos;
        end
      end
    end
  end

  // Debounce FSM stepped once per completed frame; one pulse per accepted press, no auto-repeat
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      key_code  <= CH_0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        case (state)
          S_IDLE: begin
            if (frame_kind == FR_ONE) begin
              cand <= frame_pos;
              cnt  <= CW'(1);
              if (DEBOUNCE_FRAMES == 1) begin
                key_code  <= key_map(frame_pos);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= S_PRESSED;
              end else begin
                state <= S_DEBOUNCE;
              end
            end
          end
          S_DEBOUNCE: begin
            if (frame_kind == FR_ONE) begin
              if (frame_pos == cand) begin
                cnt <= cnt + CW'(1);
                if (cnt + CW'(1) == CNT_DONE) begin
                  key_code  <= key_map(cand);
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                  state     <= S_PRESSED;
                end
              end else begin
                cand <= frame_pos;
                cnt  <= CW'(1);
              end
            end else begin
              cnt   <= '0;
              state <= S_IDLE;
            end
          end
          S_PRESSED: begin
            if (frame_kind == FR_NONE) begin
              cnt <= CW'(1);
              if (DEBOUNCE_FRAMES == 1) begin
                key_held <= 1'b0;
                state    <= S_IDLE;
              end else begin
                state <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            if (frame_kind == FR_NONE) begin
              cnt <= cnt + CW'(1);
              if (cnt + CW'(1) == CNT_DONE) begin
                key_held <= 1'b0;
                state    <= S_IDLE;
              end
            end else begin
              cnt   <= '0;
              state <= S_PRESSED;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// tb/tb_keypad_scan_decoder.sv - self-checking bench for keypad_scan_decoder
module tb_keypad_scan_decoder;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [5:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys = 16'h0000;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [5:0]  pulse_q[$];
  int          consec_err = 0;
  int          code_err = 0;
  logic        prev_valid = 1'b0;
  logic [5:0]  prev_code = 6'd0;

  keypad_scan_decoder #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 sys_clk = ~sys_clk;

  // Physical keypad: a pressed key shorts its column to its row when that row is driven low
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (row_out[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col_in[c] = 1'b0;
  end

  // Output monitor: record pulses and watch the pulse/code invariants
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (key_valid) pulse_q.push_back(key_code);
      if (key_valid && prev_valid) consec_err++;
      if (!key_valid && key_code !== prev_code) code_err++;
    end
    prev_valid = key_valid;
    prev_code  = key_code;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference key code from the printed keypad layout
  function automatic logic [5:0] expected_code(input int key);
    string layout;
    byte   ch;
    layout = "123A456B789C*0#D";
    ch = layout[key];
    if (ch == 8'h2A) return 6'd14;
    if (ch == 8'h23) return 6'd15;
    if (ch >= 8'd48 && ch <= 8'd57) return 6'(ch - 8'd48);
    return 6'(ch - 8'd65 + 8'd10);
  endfunction

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << (r*4 + c);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_pulse(input int budget);
    int t;
    t = 0;
    while (pulse_q.size() == 0 && t < budget) begin
      @(negedge sys_clk);
      t++;
    end
  endtask

  task automatic wait_release(input int budget);
    int t;
    t = 0;
    while (key_held !== 1'b0 && t < budget) begin
      @(negedge sys_clk);
      t++;
    end
  endtask

  task automatic release_all();
    keys = 16'h0000;
    wait_release(64);
    wait_cycles(48);
  endtask

  task automatic test_reset();
    logic [3:0] exp_rows [4];
    logic [3:0] cur;
    int cnt;
    exp_rows[0] = 4'b1101; exp_rows[1] = 4'b1011; exp_rows[2] = 4'b0111; exp_rows[3] = 4'b1110;
    sys_rst = 1'b1;
    wait_cycles(3);
    n_tests++; if (row_out !== 4'b1110) begin n_fail++; $display("FAIL reset_row_out: got %b, required 1110", row_out); end
    n_tests++; if (key_code !== 6'd0) begin n_fail++; $display("FAIL reset_key_code: got %0d, required 0", key_code); end
    n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b, required 0", key_valid); end
    n_tests++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_key_held: got %b, required 0", key_held); end
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cur = row_out;
      cnt = 0;
      while (row_out === cur && cnt < 8) begin
        @(negedge sys_clk);
        cnt++;
      end
      n_tests++;
      if (row_out !== exp_rows[i]) begin n_fail++; $display("FAIL row_sequence[%0d]: got %b, required %b", i, row_out, exp_rows[i]); end
      if (i > 0) begin
        n_tests++;
        if (cnt != 4) begin n_fail++; $display("FAIL row_dwell[%0d]: got %0d cycles, required 4", i, cnt); end
      end
    end
  endtask

  task automatic test_single_press();
    pulse_q.delete();
    keys = key_bit(1, 2);
    wait_pulse(56);
    n_tests++; if (pulse_q.size() != 1) begin n_fail++; $display("FAIL press6_pulse_count: got %0d, required 1", pulse_q.size()); end
    n_tests++; if (pulse_q.size() > 0 && pulse_q[0] !== expected_code(6)) begin n_fail++; $display("FAIL press6_code: got %0d, required %0d", pulse_q[0], expected_code(6)); end
    n_tests++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL press6_held: got %b, required 1", key_held); end
    wait_cycles(160);
    n_tests++; if (pulse_q.size() != 1) begin n_fail++; $display("FAIL press6_no_repeat: got %0d pulses, required 1", pulse_q.size()); end
    n_tests++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL press6_held_long: got %b, required 1", key_held); end
    keys = 16'h0000;
    wait_release(56);
    n_tests++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL press6_release: got %b, required 0", key_held); end
    release_all();
  endtask

  task automatic test_bounce();
    pulse_q.delete();
    for (int t = 0; t < 50; t++) begin
      keys = (((t / 5) % 2) == 0) ? key_bit(3, 3) : 16'h0000;
      @(negedge sys_clk);
    end
    keys = key_bit(3, 3);
    wait_pulse(56);
    wait_cycles(48);
    n_tests++; if (pulse_q.size() != 1) begin n_fail++; $display("FAIL bounce_pulse_count: got %0d, required 1", pulse_q.size()); end
    n_tests++; if (pulse_q.size() > 0 && pulse_q[0] !== expected_code(15)) begin n_fail++; $display("FAIL bounce_code: got %0d, required %0d", pulse_q[0], expected_code(15)); end
    release_all();
  endtask

  task automatic test_multi();
    pulse_q.delete();
    keys = key_bit(0, 0) | key_bit(2, 1);
    wait_cycles(96);
    n_tests++; if (pulse_q.size() != 0) begin n_fail++; $display("FAIL multi_no_pulse: got %0d pulses, required 0", pulse_q.size()); end
    n_tests++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_not_held: got %b, required 0", key_held); end
    keys = key_bit(2, 1);
    wait_pulse(56);
    wait_cycles(32);
    n_tests++; if (pulse_q.size() != 1) begin n_fail++; $display("FAIL multi_remaining_count: got %0d, required 1", pulse_q.size()); end
    n_tests++; if (pulse_q.size() > 0 && pulse_q[0] !== expected_code(9)) begin n_fail++; $display("FAIL multi_remaining_code: got %0d, required %0d", pulse_q[0], expected_code(9)); end
    release_all();
  endtask

  task automatic test_glitch();
    pulse_q.delete();
    keys = key_bit(3, 0);
    wait_cycles(16);
    keys = 16'h0000;
    wait_cycles(64);
    n_tests++; if (pulse_q.size() != 0) begin n_fail++; $display("FAIL glitch_no_pulse: got %0d pulses, required 0", pulse_q.size()); end
    keys = key_bit(3, 2);
    wait_pulse(56);
    wait_cycles(32);
    n_tests++; if (pulse_q.size() != 1) begin n_fail++; $display("FAIL hash_pulse_count: got %0d, required 1", pulse_q.size()); end
    n_tests++; if (pulse_q.size() > 0 && pulse_q[0] !== expected_code(14)) begin n_fail++; $display("FAIL hash_code: got %0d, required %0d", pulse_q[0], expected_code(14)); end
    release_all();
  endtask

  task automatic test_reset_mid();
    pulse_q.delete();
    keys = key_bit(1, 1);
    wait_cycles(24);
    n_tests++; if (pulse_q.size() != 0) begin n_fail++; $display("FAIL midrst_early_pulse: got %0d pulses, required 0", pulse_q.size()); end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    n_tests++; if (row_out !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_debounce_outputs: got row %b held %b valid %b, required 1110 0 0", row_out, key_held, key_valid); end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    pulse_q.delete();
    wait_pulse(56);
    n_tests++; if (pulse_q.size() != 1) begin n_fail++; $display("FAIL midrst_fresh_count: got %0d, required 1", pulse_q.size()); end
    n_tests++; if (pulse_q.size() > 0 && pulse_q[0] !== expected_code(5)) begin n_fail++; $display("FAIL midrst_fresh_code: got %0d, required %0d", pulse_q[0], expected_code(5)); end
    wait_cycles(8);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    n_tests++; if (key_code !== 6'd0 || key_held !== 1'b0 || row_out !== 4'b1110) begin n_fail++; $display("FAIL pressrst_outputs: got code %0d held %b row %b, required 0 0 1110", key_code, key_held, row_out); end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    pulse_q.delete();
    wait_pulse(56);
    wait_cycles(32);
    n_tests++; if (pulse_q.size() != 1) begin n_fail++; $display("FAIL pressrst_fresh_count: got %0d, required 1", pulse_q.size()); end
    n_tests++; if (pulse_q.size() > 0 && pulse_q[0] !== expected_code(5)) begin n_fail++; $display("FAIL pressrst_fresh_code: got %0d, required %0d", pulse_q[0], expected_code(5)); end
    release_all();
  endtask

  task automatic test_random();
    logic held_m;
    int   kind, k1, k2, len, exp_n;
    logic [5:0] exp_c;
    held_m = 1'b0;
    for (int s = 0; s < 14; s++) begin
      kind  = int'($urandom_range(0, 2));
      k1    = int'($urandom_range(0, 15));
      k2    = (k1 + 1 + int'($urandom_range(0, 14))) % 16;
      len   = int'($urandom_range(64, 96));
      exp_n = 0;
      exp_c = 6'd0;
      pulse_q.delete();
      if (kind == 0) begin
        keys   = 16'h0000;
        held_m = 1'b0;
      end else if (kind == 1) begin
        keys = key_bit(k1 / 4, k1 % 4);
        if (!held_m) begin
          exp_n  = 1;
          exp_c  = expected_code(k1);
          held_m = 1'b1;
        end
      end else begin
        keys = key_bit(k1 / 4, k1 % 4) | key_bit(k2 / 4, k2 % 4);
      end
      wait_cycles(len);
      n_tests++; if (pulse_q.size() != exp_n) begin n_fail++; $display("FAIL random_seg%0d_count: kind %0d keys %h got %0d pulses, required %0d", s, kind, keys, pulse_q.size(), exp_n); end
      if (exp_n == 1 && pulse_q.size() > 0) begin
        n_tests++; if (pulse_q[0] !== exp_c) begin n_fail++; $display("FAIL random_seg%0d_code: got %0d, required %0d", s, pulse_q[0], exp_c); end
      end
      n_tests++; if (key_held !== held_m) begin n_fail++; $display("FAIL random_seg%0d_held: got %b, required %b", s, key_held, held_m); end
    end
    release_all();
  endtask

  task automatic test_invariants();
    n_tests++; if (consec_err != 0) begin n_fail++; $display("FAIL valid_consecutive: got %0d occurrences, required 0", consec_err); end
    n_tests++; if (code_err != 0) begin n_fail++; $display("FAIL code_without_valid: got %0d occurrences, required 0", code_err); end
  endtask

  initial begin
    test_reset();
    wait_cycles(16);
    test_single_press();
    test_bounce();
    test_multi();
    test_glitch();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
